// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP execute stage: widths, opcode encoding,
// saturation limits and a helper telling which opcodes write the register file.
package dsp_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 40;
    localparam int REG_N  = 16;
    localparam int REG_AW = 4;

    localparam logic [DATA_W-1:0] SAT32_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT32_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MUL    = 3'd3,
        OP_MAC    = 3'd4,
        OP_MACW   = 3'd5,
        OP_RDACC  = 3'd6,
        OP_CLRACC = 3'd7
    } op_e;

    // Opcodes that produce a register-file write (still gated by rd != 0).
    function automatic logic op_writes(input op_e o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL) ||
               (o == OP_MACW) || (o == OP_RDACC);
    endfunction

endpackage

// File: rtl/dsp_sat.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits.
//   value_i : signed input (IN_W bits, IN_W > OUT_W)
//   value_o : input clamped to the signed OUT_W range
//   ovf_o   : 1 when clamping occurred
module dsp_sat #(
    parameter int IN_W  = 41,
    parameter int OUT_W = 40
) (
    input  logic [IN_W-1:0]  value_i,
    output logic [OUT_W-1:0] value_o,
    output logic             ovf_o
);

    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits iff every bit from the input sign down to the output
    // sign position agrees.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = value_i[IN_W-1:OUT_W-1];
    assign ovf_o    = !((&top_bits) || !(|top_bits));
    assign value_o  = ovf_o ? (value_i[IN_W-1] ? MIN_V : MAX_V)
                            : value_i[OUT_W-1:0];

endmodule

// File: rtl/dsp_exec_stage.sv
// Two-stage execute pipeline (E1 operand register, E2 write-back register)
// with a 40-bit saturating accumulator and RAW interlock against in-flight
// destinations (the register file has no bypass).
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : issue handshake; in_ready drops on a RAW hazard
//   op, ra, rb, rd, a, b : opcode, source/destination indices, operands
//   wb_we/wb_rw/wb_wdata : register-file write port (captured next edge)
//   acc_out, sat_flag    : accumulator and sticky saturation flag
//   pend_mask            : one bit per register with a write in flight
module dsp_exec_stage
    import dsp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rw,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat_flag,
    output logic [REG_N-1:0]  pend_mask
);

    // E1 stage
    logic              e1_valid_q;
    op_e               e1_op_q;
    logic [REG_AW-1:0] e1_rd_q;
    logic [DATA_W-1:0] e1_a_q, e1_b_q;
    // E2 stage
    logic              wb_we_q, wb_we_d;
    logic [REG_AW-1:0] wb_rw_q;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    // Accumulator
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;

    logic              hz;
    logic              e1_writes;

    assign e1_writes = e1_valid_q && op_writes(e1_op_q) && (e1_rd_q != '0);

    genvar gi;
    generate
        for (gi = 0; gi < REG_N; gi++) begin : g_pend
            if (gi == 0) begin : g_r0
                assign pend_mask[gi] = 1'b0;
            end else begin : g_rn
                assign pend_mask[gi] = (e1_writes && (e1_rd_q == REG_AW'(gi))) ||
                                       (wb_we_q   && (wb_rw_q == REG_AW'(gi)));
            end
        end
    endgenerate

    assign hz       = ((ra != '0) && pend_mask[ra]) || ((rb != '0) && pend_mask[rb]);
    assign in_ready = !hz;

    // Low half of a product is the same for signed and unsigned operands.
    logic [DATA_W-1:0] mul_lo;
    assign mul_lo = e1_a_q * e1_b_q;

    logic signed [DATA_W-1:0] mac_a, mac_b, mac_prod;
    assign mac_a    = DATA_W'($signed(e1_a_q[15:0]));
    assign mac_b    = DATA_W'($signed(e1_b_q[15:0]));
    assign mac_prod = mac_a * mac_b;

    // One guard bit so the sum cannot wrap before it is clamped.
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_mac;
    logic             acc_ovf;
    assign acc_sum = {acc_q[ACC_W-1], acc_q} +
                     {{(ACC_W+1-DATA_W){mac_prod[DATA_W-1]}}, mac_prod};

    dsp_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W)) u_sat_acc (
        .value_i (acc_sum),
        .value_o (acc_mac),
        .ovf_o   (acc_ovf)
    );

    // MACW narrows the freshly accumulated value; RDACC the stored one.
    logic [ACC_W-1:0]  s32_in;
    logic [DATA_W-1:0] s32_val;
    logic              s32_ovf;
    assign s32_in = (e1_op_q == OP_MACW) ? acc_mac : acc_q;

    dsp_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_32 (
        .value_i (s32_in),
        .value_o (s32_val),
        .ovf_o   (s32_ovf)
    );

    always_comb begin
        acc_d      = acc_q;
        sat_d      = sat_q;
        wb_wdata_d = '0;
        wb_we_d    = e1_writes;
        if (e1_valid_q) begin
            case (e1_op_q)
                OP_ADD:  wb_wdata_d = e1_a_q + e1_b_q;
                OP_SUB:  wb_wdata_d = e1_a_q - e1_b_q;
                OP_MUL:  wb_wdata_d = mul_lo;
                OP_MAC: begin
                    acc_d = acc_mac;
                    sat_d = sat_q | acc_ovf;
                end
                OP_MACW: begin
                    acc_d      = acc_mac;
                    sat_d      = sat_q | acc_ovf | s32_ovf;
                    wb_wdata_d = s32_val;
                end
                OP_RDACC: begin
                    sat_d      = sat_q | s32_ovf;
                    wb_wdata_d = s32_val;
                end
                OP_CLRACC: begin
                    acc_d = '0;
                    sat_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid_q <= 1'b0;
            e1_op_q    <= OP_NOP;
            e1_rd_q    <= '0;
            e1_a_q     <= '0;
            e1_b_q     <= '0;
            wb_we_q    <= 1'b0;
            wb_rw_q    <= '0;
            wb_wdata_q <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            e1_valid_q <= in_valid && !hz;
            e1_op_q    <= op_e'(op);
            e1_rd_q    <= rd;
            e1_a_q     <= a;
            e1_b_q     <= b;
            wb_we_q    <= wb_we_d;
            wb_rw_q    <= e1_rd_q;
            wb_wdata_q <= wb_wdata_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
        end
    end

    assign wb_we    = wb_we_q;
    assign wb_rw    = wb_rw_q;
    assign wb_wdata = wb_wdata_q;
    assign acc_out  = acc_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_dsp_exec_stage.sv
module tb_dsp_exec_stage;
    import dsp_pkg::*;

    localparam longint ACC_HI = 64'sd549755813887;
    localparam longint ACC_LO = -64'sd549755813888;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [3:0]  ra = 4'd0, rb = 4'd0, rd = 4'd0;
    logic [31:0] a, b;
    logic        wb_we;
    logic [3:0]  wb_rw;
    logic [31:0] wb_wdata;
    logic [39:0] acc_out;
    logic        sat_flag;
    logic [15:0] pend_mask;

    dsp_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ra(ra), .rb(rb), .rd(rd), .a(a), .b(b),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_wdata(wb_wdata),
        .acc_out(acc_out), .sat_flag(sat_flag), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write on the clock edge.
    logic [31:0] rf [16] = '{default: '0};
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;
    assign a = rf[ra];
    assign b = rf[rb];
    always @(posedge clk) begin
        if (pre_we) rf[pre_idx] <= pre_val;
        if (wb_we)  rf[wb_rw]   <= wb_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Architectural model
    logic [31:0] arch [16] = '{default: '0};
    longint      m_acc = 0;
    logic        m_sat = 1'b0;

    typedef struct {
        int          due;
        logic        we;
        logic [3:0]  rw;
        logic [31:0] wd;
        logic [39:0] acc;
        logic        sat;
    } sb_entry_t;
    sb_entry_t sb[$];
    sb_entry_t e_chk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32_model(input longint v);
        if (v > 64'sd2147483647) begin
            m_sat = 1'b1;
            return 32'h7FFF_FFFF;
        end else if (v < -64'sd2147483648) begin
            m_sat = 1'b1;
            return 32'h8000_0000;
        end
        return v[31:0];
    endfunction

    function automatic void model_exec(input logic [2:0] o, input logic [31:0] av, bv,
                                       output logic we, output logic [31:0] wd);
        longint p, s;
        we = 1'b0;
        wd = '0;
        case (o)
            OP_ADD: begin wd = av + bv; we = 1'b1; end
            OP_SUB: begin wd = av - bv; we = 1'b1; end
            OP_MUL: begin
                p  = longint'($signed(av)) * longint'($signed(bv));
                wd = p[31:0];
                we = 1'b1;
            end
            OP_MAC, OP_MACW: begin
                p = longint'($signed(av[15:0])) * longint'($signed(bv[15:0]));
                s = m_acc + p;
                if (s > ACC_HI) begin s = ACC_HI; m_sat = 1'b1; end
                else if (s < ACC_LO) begin s = ACC_LO; m_sat = 1'b1; end
                m_acc = s;
                if (o == OP_MACW) begin wd = sat32_model(m_acc); we = 1'b1; end
            end
            OP_RDACC: begin wd = sat32_model(m_acc); we = 1'b1; end
            OP_CLRACC: begin m_acc = 0; m_sat = 1'b0; end
            default: ;
        endcase
    endfunction

    // Output checker: runs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e_chk = sb.pop_front();
                $display("txn cyc=%0d we=%0b rw=%0d wdata=%08h acc=%010h sat=%0b",
                         cyc, wb_we, wb_rw, wb_wdata, acc_out, sat_flag);
                chk("wb_we", 64'(wb_we), 64'(e_chk.we));
                if (e_chk.we) begin
                    chk("wb_rw", 64'(wb_rw), 64'(e_chk.rw));
                    chk("wb_wdata", 64'(wb_wdata), 64'(e_chk.wd));
                end
                chk("acc_out", 64'(acc_out), 64'(e_chk.acc));
                chk("sat_flag", 64'(sat_flag), 64'(e_chk.sat));
            end else if (wb_we) begin
                chk("wb_we_idle", 64'(wb_we), 64'd0);
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows acceptance.
    task automatic issue(input logic [2:0] o, input logic [3:0] d, s1, s2, output int stalls);
        sb_entry_t   ent;
        logic        we;
        logic [31:0] wd;
        op = o; rd = d; ra = s1; rb = s2; in_valid = 1'b1;
        stalls = 0;
        forever begin
            #2;
            if (in_ready) break;
            stalls++;
            if (stalls > 40) begin
                chk("issue_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        model_exec(o, arch[s1], arch[s2], we, wd);
        ent.due = cyc + 2;
        ent.we  = we && (d != 4'd0);
        ent.rw  = d;
        ent.wd  = wd;
        ent.acc = m_acc[39:0];
        ent.sat = m_sat;
        if (ent.we) arch[d] = wd;
        sb.push_back(ent);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue0(input logic [2:0] o, input logic [3:0] d, s1, s2);
        int st;
        issue(o, d, s1, s2, st);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] v);
        pre_we = 1'b1; pre_idx = idx; pre_val = v;
        arch[idx] = v;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int st;
        logic [31:0] save9, save10;

        vecs[0] = '{op: OP_MUL, av: 32'hFFFF_FFFD, bv: 32'h7FFF_FFFF, exp: 32'h8000_0003};
        vecs[1] = '{op: OP_SUB, av: 32'h0000_0000, bv: 32'h0000_0001, exp: 32'hFFFF_FFFF};
        vecs[2] = '{op: OP_ADD, av: 32'h7FFF_FFFF, bv: 32'h0000_0001, exp: 32'h8000_0000};
        vecs[3] = '{op: OP_ADD, av: 32'd5,         bv: 32'd6,         exp: 32'd11};
        vecs[4] = '{op: OP_SUB, av: 32'd10,        bv: 32'd3,         exp: 32'd7};
        vecs[5] = '{op: OP_MUL, av: 32'h0001_0000, bv: 32'h0001_0000, exp: 32'h0000_0000};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_rw", 64'(wb_rw), 64'd0);
        chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Table-driven independent ALU ops
        for (int i = 0; i < 6; i++) begin
            preload(4'd3, vecs[i].av);
            preload(4'd4, vecs[i].bv);
            issue0(vecs[i].op, 4'd7, 4'd3, 4'd4);
            idle(3);
            chk($sformatf("vec%0d_result", i), 64'(rf[7]), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_sat", i), 64'(sat_flag), 64'd0);
        end

        // RAW hazard on both sources
        preload(4'd3, 32'd3);
        preload(4'd4, 32'd4);
        issue(OP_ADD, 4'd1, 4'd3, 4'd4, st);
        chk("pend_r1", 64'(pend_mask), 64'h0002);
        issue(OP_ADD, 4'd2, 4'd1, 4'd1, st);
        chk("raw_both_stalls", 64'(st), 64'd2);
        idle(4);
        chk("raw_r2", 64'(rf[2]), 64'd14);

        // RAW hazard on rb only, then an independent op
        issue(OP_ADD, 4'd8, 4'd3, 4'd4, st);
        issue(OP_SUB, 4'd13, 4'd4, 4'd8, st);
        chk("raw_rb_stalls", 64'(st), 64'd2);
        issue(OP_ADD, 4'd14, 4'd3, 4'd4, st);
        chk("indep_stalls", 64'(st), 64'd0);
        idle(4);
        chk("raw_r13", 64'(rf[13]), 64'hFFFF_FFFD);

        // rd = 0: no write, no pending bit, no stall on r0 readers
        issue(OP_ADD, 4'd0, 4'd3, 4'd4, st);
        chk("pend_rd0", 64'(pend_mask), 64'd0);
        issue(OP_ADD, 4'd5, 4'd0, 4'd0, st);
        chk("r0_stalls", 64'(st), 64'd0);
        issue0(OP_MACW, 4'd0, 4'd3, 4'd4);
        idle(3);

        // MAC then RDACC back-to-back, sat32 clamp, then clear
        issue0(OP_CLRACC, 4'd0, 4'd0, 4'd0);
        preload(4'd11, 32'h0000_7FFF);
        for (int i = 0; i < 4; i++) issue0(OP_MAC, 4'd0, 4'd11, 4'd11);
        issue(OP_RDACC, 4'd6, 4'd0, 4'd0, st);
        chk("rdacc_stalls", 64'(st), 64'd0);
        idle(4);
        chk("mac4_acc", 64'(acc_out), 64'h00_FFFC_0004);
        chk("rdacc_r6", 64'(rf[6]), 64'h7FFF_FFFF);
        chk("rdacc_sat", 64'(sat_flag), 64'd1);
        issue0(OP_CLRACC, 4'd0, 4'd0, 4'd0);
        idle(2);
        chk("clr_acc", 64'(acc_out), 64'd0);
        chk("clr_sat", 64'(sat_flag), 64'd0);

        // 512 x (+2^30) reaches and clamps at 2^39-1
        preload(4'd11, 32'hFFFF_8000);
        preload(4'd12, 32'h0000_8000);
        for (int i = 0; i < 512; i++) issue0(OP_MAC, 4'd0, 4'd11, 4'd12);
        idle(3);
        chk("acc_clamp", 64'(acc_out), 64'(ACC_MAX));
        chk("acc_clamp_sat", 64'(sat_flag), 64'd1);

        // Reset with ADD in E2 and MUL in E1
        preload(4'd9, 32'hA5A5_A5A5);
        preload(4'd10, 32'h5A5A_5A5A);
        save9 = arch[9];
        save10 = arch[10];
        issue0(OP_ADD, 4'd9, 4'd3, 4'd4);
        issue0(OP_MUL, 4'd10, 4'd3, 4'd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_we", 64'(wb_we), 64'd0);
        chk("arst_wb_rw", 64'(wb_rw), 64'd0);
        chk("arst_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("arst_acc", 64'(acc_out), 64'd0);
        chk("arst_sat", 64'(sat_flag), 64'd0);
        chk("arst_pend", 64'(pend_mask), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        sb.delete();
        m_acc = 0;
        m_sat = 1'b0;
        arch[9] = save9;
        arch[10] = save10;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("arst_r9", 64'(rf[9]), 64'(save9));
        chk("arst_r10", 64'(rf[10]), 64'(save10));
        chk("arst_acc_after", 64'(acc_out), 64'd0);

        idle(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
